palette_pixel_mapper: RTL and testbench

//  Consumer end of the level palette. Converts a stream of 2-bit block-pixel colour indices into
//  12-bit RGB using the four level colours (COLOR_0..COLOR_3) driven by the palette.
//  The palette is latched once per frame, so a level change never tears a frame.
//  On a level change it flashes the playfield for a few frames.

---
 rtl/palette_pkg.sv | 31 +++
 rtl/pix_pipe_stage.sv | 58 +++++
 rtl/palette_pixel_mapper.sv | 141 ++++++++++++++
 tb/tb_palette_pixel_mapper.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette pixel mapper slice.
// Contents:
//   color_t   12-bit {R[3:0],G[3:0],B[3:0]} colour
//   cidx_t    2-bit colour index into the four-entry level palette
//   level_t   3-bit level number
//   IDX_BLACK index that is never flashed
//   IDX_WHITE index whose colour replaces the others during a flash frame
//   map_color palette lookup including the flash override
package palette_pkg;

  typedef logic [11:0] color_t;
  typedef logic [1:0]  cidx_t;
  typedef logic [2:0]  level_t;

  localparam cidx_t IDX_BLACK = 2'd2;
  localparam cidx_t IDX_WHITE = 2'd3;

  // During a flash frame every index except black shows the white entry.
  function automatic color_t map_color(input logic [3:0][11:0] tbl,
                                       input cidx_t            idx,
                                       input logic             flash);
    color_t c;
    if (flash && (idx != IDX_BLACK)) begin
      c = tbl[IDX_WHITE];
    end else begin
      c = tbl[idx];
    end
    return c;
  endfunction

endpackage

// File: rtl/pix_pipe_stage.sv
// Generic valid/ready register slice.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_data [W-1:0]     upstream payload
//   out_valid/out_ready downstream handshake (out_valid is registered)
//   out_data [W-1:0]    registered payload
// The slice accepts whenever it is empty or its content is leaving this edge,
// so bubbles collapse and a full chain still moves one item per cycle.
module pix_pipe_stage #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: load on advance, otherwise hold the stalled item.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/palette_pixel_mapper.sv
// Maps a stream of 2-bit colour indices to 12-bit RGB through the level
// palette, which is latched on the first pixel of each frame so that a level
// change never tears a frame. A level change starts a flash effect that
// whitens the playfield on alternate frames, beginning with the change frame.
// Ports:
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   LEVEL                        current level, sampled on the first pixel
//   COLOR_0..COLOR_3             palette colours, sampled on the first pixel
//   PIX_VALID/PIX_READY          input handshake
//   PIX_IDX, PIX_LAST            input colour index and end-of-frame flag
//   RGB_VALID/RGB_READY          output handshake
//   RGB, RGB_LAST                registered output colour and end-of-frame
// Pipeline: S1 holds {idx,last}; the lookup happens on the S1->S2 move, and
// S2 holds {rgb,last}.
module palette_pixel_mapper
  import palette_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned CNT_W        = $clog2(FLASH_FRAMES + 1)
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [2:0]  LEVEL,
  input  logic [11:0] COLOR_0,
  input  logic [11:0] COLOR_1,
  input  logic [11:0] COLOR_2,
  input  logic [11:0] COLOR_3,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic [1:0]  PIX_IDX,
  input  logic        PIX_LAST,
  output logic        RGB_VALID,
  input  logic        RGB_READY,
  output logic [11:0] RGB,
  output logic        RGB_LAST
);

  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0][11:0] table_q, table_d;
  level_t           lvl_q, lvl_d;
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic             flash_q, flash_d;
  logic             sof_q, sof_d;

  logic             accept_s;
  logic             sof_evt_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             s1_valid_s;
  logic             s2_ready_s;
  logic [2:0]       s1_data_s;
  logic [12:0]      s2_in_s;
  logic [12:0]      s2_data_s;

  pix_pipe_stage #(.W(3)) u_s1 (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .in_valid  (PIX_VALID),
    .in_ready  (PIX_READY),
    .in_data   ({PIX_IDX, PIX_LAST}),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_data_s)
  );

  // Lookup uses the table/flash currently held, i.e. before any SOF update
  // on the same edge, so a frame's tail pixels keep that frame's palette.
  assign s2_in_s = {map_color(table_q, s1_data_s[2:1], flash_q), s1_data_s[0]};

  pix_pipe_stage #(.W(13)) u_s2 (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (RGB_VALID),
    .out_ready (RGB_READY),
    .out_data  (s2_data_s)
  );

  assign RGB      = s2_data_s[12:1];
  assign RGB_LAST = s2_data_s[0];

  // Frame-start tracking, palette latch and flash countdown.
  always_comb begin
    accept_s  = PIX_VALID && PIX_READY;
    sof_evt_s = accept_s && sof_q;

    if (LEVEL != lvl_q) begin
      cnt_next_s = FLASH_LOAD;
    end else if (flash_cnt_q != CNT_ZERO) begin
      cnt_next_s = flash_cnt_q - CNT_ONE;
    end else begin
      cnt_next_s = CNT_ZERO;
    end

    table_d     = table_q;
    lvl_d       = lvl_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    if (sof_evt_s) begin
      table_d     = {COLOR_3, COLOR_2, COLOR_1, COLOR_0};
      lvl_d       = LEVEL;
      flash_cnt_d = cnt_next_s;
      // Even non-zero counts flash: the change frame (count = FLASH_FRAMES)
      // flashes, the next one does not, and so on.
      flash_d     = (cnt_next_s != CNT_ZERO) && !cnt_next_s[0];
    end else begin
      table_d     = table_q;
      lvl_d       = lvl_q;
      flash_cnt_d = flash_cnt_q;
      flash_d     = flash_q;
    end

    if (accept_s) begin
      sof_d = PIX_LAST;
    end else begin
      sof_d = sof_q;
    end
  end

  // Palette, level and flash state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      table_q     <= {4{12'h000}};
      lvl_q       <= 3'd0;
      flash_cnt_q <= CNT_ZERO;
      flash_q     <= 1'b0;
      sof_q       <= 1'b1;
    end else begin
      table_q     <= table_d;
      lvl_q       <= lvl_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      sof_q       <= sof_d;
    end
  end

endmodule

// File: tb/tb_palette_pixel_mapper.sv
// Self-checking bench for palette_pixel_mapper (FLASH_FRAMES = 4).
// A frame-level model predicts each output pixel at input acceptance; a
// monitor compares every output transfer against it and checks that stalled
// outputs hold. Literal expectations pin the model on each scenario.
module tb_palette_pixel_mapper;

  localparam int FF = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [2:0]  LEVEL;
  logic [11:0] COLOR_0, COLOR_1, COLOR_2, COLOR_3;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [1:0]  PIX_IDX;
  logic        PIX_LAST;
  logic        RGB_VALID;
  logic        RGB_READY;
  logic [11:0] RGB;
  logic        RGB_LAST;

  palette_pixel_mapper #(.FLASH_FRAMES(FF)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .LEVEL     (LEVEL),
    .COLOR_0   (COLOR_0),
    .COLOR_1   (COLOR_1),
    .COLOR_2   (COLOR_2),
    .COLOR_3   (COLOR_3),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .PIX_IDX   (PIX_IDX),
    .PIX_LAST  (PIX_LAST),
    .RGB_VALID (RGB_VALID),
    .RGB_READY (RGB_READY),
    .RGB       (RGB),
    .RGB_LAST  (RGB_LAST)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model state: per-frame palette, level, frames since last level change.
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  logic [11:0] m_tbl[4];
  logic [2:0]  m_lvl;
  int          m_k;
  logic        m_sof;
  logic        held;
  logic [11:0] held_rgb;
  logic        held_last;

  task automatic model_accept();
    logic        flash;
    logic [11:0] c;
    if (m_sof) begin
      m_tbl[0] = COLOR_0; m_tbl[1] = COLOR_1; m_tbl[2] = COLOR_2; m_tbl[3] = COLOR_3;
      if (LEVEL != m_lvl) m_k = 0;
      else if (m_k < FF) m_k = m_k + 1;
      m_lvl = LEVEL;
    end
    flash = (m_k < FF) && ((m_k % 2) == 0);
    if (flash && PIX_IDX != 2'd2) c = m_tbl[3];
    else c = m_tbl[PIX_IDX];
    exp_q.push_back({c, PIX_LAST});
    m_sof = PIX_LAST;
  endtask

  // Monitor: sample between edges, compare transfers, check stall holding.
  initial begin
    logic [12:0] e;
    m_sof = 1'b1; m_lvl = 3'd0; m_k = FF; held = 1'b0;
    held_rgb = 12'h000; held_last = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        exp_q.delete();
        m_sof = 1'b1; m_lvl = 3'd0; m_k = FF; held = 1'b0;
      end else begin
        if (held) begin
          vectors++;
          if (!(RGB_VALID && RGB == held_rgb && RGB_LAST == held_last)) begin
            miscompares++;
            $display("FAIL hold: got v=%0b rgb=%h last=%0b, need v=1 rgb=%h last=%0b",
                     RGB_VALID, RGB, RGB_LAST, held_rgb, held_last);
          end
        end
        if (RGB_VALID && RGB_READY) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got rgb=%h last=%0b, need none", RGB, RGB_LAST);
          end else begin
            e = exp_q.pop_front();
            if ({RGB, RGB_LAST} != e) begin
              miscompares++;
              $display("FAIL stream: got rgb=%h last=%0b, need rgb=%h last=%0b",
                       RGB, RGB_LAST, e[12:1], e[0]);
            end
          end
          obs_q.push_back({RGB, RGB_LAST});
        end
        held      = RGB_VALID && !RGB_READY;
        held_rgb  = RGB;
        held_last = RGB_LAST;
        if (PIX_VALID && PIX_READY) model_accept();
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  task automatic check_obs(input string name, input logic [11:0] rgb, input logic last);
    logic [12:0] o;
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got no output, need rgb=%h last=%0b", name, rgb, last);
    end else begin
      o = obs_q.pop_front();
      if (o != {rgb, last}) begin
        miscompares++;
        $display("FAIL %s: got rgb=%h last=%0b, need rgb=%h last=%0b", name, o[12:1], o[0], rgb, last);
      end
    end
  endtask

  task automatic send(input logic [1:0] idx, input logic last);
    int   guard;
    logic acc;
    PIX_VALID = 1'b1; PIX_IDX = idx; PIX_LAST = last;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge CLK);
      acc = PIX_READY;
      @(posedge CLK);
      #1;
      guard++;
    end
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got PIX_READY=0 for 100 cycles, need 1");
    end
  endtask

  task automatic idle();
    PIX_VALID = 1'b0; PIX_IDX = 2'd0; PIX_LAST = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge CLK);
      g++;
    end
    #1;
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending, need 0", exp_q.size());
    end
  endtask

  task automatic set_pal(input logic [11:0] c0, input logic [11:0] c1,
                         input logic [11:0] c2, input logic [11:0] c3);
    COLOR_0 = c0; COLOR_1 = c1; COLOR_2 = c2; COLOR_3 = c3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; RGB_READY = 1'b1; LEVEL = 3'd0;
    set_pal(12'h000, 12'h000, 12'h000, 12'h000);
    idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rgb_valid", 16'(RGB_VALID), 16'h0);
    chk("rst_pix_ready", 16'(PIX_READY), 16'h1);
    chk("rst_rgb", 16'(RGB), 16'h000);
    chk("rst_rgb_last", 16'(RGB_LAST), 16'h0);
    RESET_N = 1'b1;

    // Reset in the middle of a frame
    LEVEL = 3'd3;
    set_pal(12'h123, 12'h456, 12'h000, 12'h789);
    send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd3, 1'b0);
    idle();
    RESET_N = 1'b0;
    #1;
    chk("midrst_rgb_valid", 16'(RGB_VALID), 16'h0);
    chk("midrst_pix_ready", 16'(PIX_READY), 16'h1);
    chk("midrst_rgb", 16'(RGB), 16'h000);
    @(negedge CLK); @(posedge CLK); #1;
    RESET_N = 1'b1;

    // Basic frame, latency and palette capture on first pixel after reset
    obs_q.delete();
    LEVEL = 3'd0;
    set_pal(12'h5df, 12'h06f, 12'h000, 12'hfff);
    send(2'd0, 1'b0);
    chk("lat1_rgb_valid", 16'(RGB_VALID), 16'h0);
    send(2'd1, 1'b0);
    chk("lat2_rgb_valid", 16'(RGB_VALID), 16'h1);
    chk("lat2_rgb", 16'(RGB), 16'h5df);
    send(2'd2, 1'b0); send(2'd3, 1'b1);
    idle(); drain();
    check_obs("t2_p0", 12'h5df, 1'b0);
    check_obs("t2_p1", 12'h06f, 1'b0);
    check_obs("t2_p2", 12'h000, 1'b0);
    check_obs("t2_p3", 12'hfff, 1'b1);

    // Mid-frame level/palette change takes effect at the next frame
    obs_q.delete();
    send(2'd0, 1'b0); send(2'd1, 1'b0);
    LEVEL = 3'd1;
    set_pal(12'haf0, 12'h8d0, 12'h000, 12'hfff);
    send(2'd0, 1'b0); send(2'd1, 1'b1);
    send(2'd0, 1'b0); send(2'd2, 1'b1);
    send(2'd0, 1'b1);
    idle(); drain();
    check_obs("t3_old0", 12'h5df, 1'b0);
    check_obs("t3_old1", 12'h06f, 1'b0);
    check_obs("t3_old2", 12'h5df, 1'b0);
    check_obs("t3_old3", 12'h06f, 1'b1);
    check_obs("t3_flash0", 12'hfff, 1'b0);
    check_obs("t3_flash_blk", 12'h000, 1'b1);
    check_obs("t3_new0", 12'haf0, 1'b1);

    // Flash sequence over five frames after a level change
    obs_q.delete();
    LEVEL = 3'd2;
    for (int f = 0; f < 5; f++) begin
      send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b1);
    end
    idle(); drain();
    for (int f = 0; f < 5; f++) begin
      if (f == 0 || f == 2) begin
        check_obs("t4_fl_i0", 12'hfff, 1'b0);
        check_obs("t4_fl_i1", 12'hfff, 1'b0);
      end else begin
        check_obs("t4_nm_i0", 12'haf0, 1'b0);
        check_obs("t4_nm_i1", 12'h8d0, 1'b0);
      end
      check_obs("t4_i2", 12'h000, 1'b1);
    end

    // Backpressure with a full pipeline
    obs_q.delete();
    RGB_READY = 1'b0;
    send(2'd0, 1'b0); send(2'd1, 1'b0);
    PIX_VALID = 1'b1; PIX_IDX = 2'd2; PIX_LAST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t5_pix_ready", 16'(PIX_READY), 16'h0);
      chk("t5_rgb_held", 16'(RGB), 16'haf0);
      @(posedge CLK); #1;
    end
    RGB_READY = 1'b1;
    send(2'd2, 1'b0); send(2'd3, 1'b1);
    idle(); drain();
    check_obs("t5_p0", 12'haf0, 1'b0);
    check_obs("t5_p1", 12'h8d0, 1'b0);
    check_obs("t5_p2", 12'h000, 1'b0);
    check_obs("t5_p3", 12'hfff, 1'b1);
    chk("t5_no_extra", 16'(obs_q.size()), 16'h0);

    // Back-to-back single-pixel frames with alternating level
    obs_q.delete();
    LEVEL = 3'd0; set_pal(12'h5df, 12'h06f, 12'h000, 12'hf0f);
    send(2'd1, 1'b1);
    LEVEL = 3'd1; set_pal(12'haf0, 12'h8d0, 12'h000, 12'h0ff);
    send(2'd1, 1'b1);
    LEVEL = 3'd0; set_pal(12'h5df, 12'h06f, 12'h000, 12'hf0f);
    send(2'd1, 1'b1);
    send(2'd1, 1'b1);
    idle(); drain();
    check_obs("t6_l0", 12'hf0f, 1'b1);
    check_obs("t6_l1", 12'h0ff, 1'b1);
    check_obs("t6_l0b", 12'hf0f, 1'b1);
    check_obs("t6_l0c", 12'h06f, 1'b1);

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
